// File: rtl/incr_mon_pkg.sv
// Shared types and defaults for the incrementing-stream monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package incr_mon_pkg;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  // The streak counter must be able to hold the value LOCK_N itself.
  function automatic int streak_w(input int lock_n);
    return $clog2(lock_n + 1);
  endfunction

endpackage

// File: rtl/incr_stream_monitor_if.sv
// Sample bus from the upstream counter stage into the monitor.
// Latency: n/a (wires only).
// Backpressure: none; every valid sample is consumed by the slave.
//   in_valid : sample present this cycle
//   in_data  : sample value
interface incr_stream_monitor_if
  import incr_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for the error and wrap event tallies.
// Latency: q reflects an inc one cycle after the edge that samples it.
// Backpressure: none; holds at all-ones once saturated.
//   clk, rst (sync, active-high), clr (sync soft clear), inc, q
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/incr_stream_monitor.sv
// Checks an incrementing sample stream, declares lock after LOCK_N good steps,
// and reports step errors / wrap-arounds. Latency: all outputs one cycle after
// the accepting edge. Backpressure: none; every valid sample is accepted.
//   clk, rst      : clock, synchronous active-high reset
//   in_if         : sample bus (in_valid, in_data), slave side
//   clear         : synchronous soft clear, same effect as rst
//   locked        : high while in S_LOCKED
//   err_pulse     : 1-cycle pulse on a mismatch while locked
//   wrap_pulse    : 1-cycle pulse on a matching step that wrapped
//   err_count     : saturating count of err_pulse events
//   wrap_count    : saturating count of wrap_pulse events
//   last_data     : most recently accepted sample
module incr_stream_monitor
  import incr_mon_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP   = 1,
  parameter int LOCK_N = 4,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  incr_stream_monitor_if.slave in_if,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 wrap_pulse,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     wrap_count,
  output logic [WIDTH-1:0]     last_data
);

  localparam int               SW        = streak_w(LOCK_N);
  localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
  // Streak value at which one more match completes the lock.
  localparam logic [SW-1:0]    LOCK_LAST = SW'(LOCK_N - 1);

  state_t           state_q;
  logic [SW-1:0]    streak_q;
  logic [WIDTH-1:0] last_q;
  logic             locked_q;
  logic             err_q;
  logic             wrap_q;

  logic [WIDTH-1:0] exp_data;
  logic             live;
  logic             match;
  logic             wrapped;
  logic             err_evt;
  logic             wrap_evt;

  // A sample arriving together with clear is dropped.
  assign live     = in_if.in_valid & ~clear;
  assign exp_data = last_q + STEP_W;
  assign match    = in_if.in_valid & (in_if.in_data == exp_data);
  assign wrapped  = match & (in_if.in_data < last_q);

  // In S_EMPTY last_q holds no accepted sample, so neither event may fire there.
  assign err_evt  = live & ~match & (state_q == S_LOCKED);
  assign wrap_evt = live & wrapped & (state_q != S_EMPTY);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q  <= S_EMPTY;
      streak_q <= '0;
      last_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      err_q  <= err_evt;
      wrap_q <= wrap_evt;
      if (in_if.in_valid) begin
        last_q <= in_if.in_data;
        case (state_q)
          S_EMPTY: begin
            state_q  <= S_ACQUIRE;
            streak_q <= '0;
            locked_q <= 1'b0;
          end
          S_ACQUIRE: begin
            if (match) begin
              streak_q <= streak_q + SW'(1);
              if (streak_q == LOCK_LAST) begin
                state_q  <= S_LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              streak_q <= '0;
            end
          end
          S_LOCKED: begin
            if (!match) begin
              state_q  <= S_ACQUIRE;
              streak_q <= '0;
              locked_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= S_EMPTY;
            streak_q <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (err_evt),
    .q   (err_count)
  );

  sat_counter #(.W(CNT_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (wrap_evt),
    .q   (wrap_count)
  );

  assign locked     = locked_q;
  assign err_pulse  = err_q;
  assign wrap_pulse = wrap_q;
  assign last_data  = last_q;

endmodule

// File: tb/tb_incr_stream_monitor.sv
// Scoreboard bench for incr_stream_monitor: two instances (16-bit and 4-bit
// counters) share one sample bus; expected outputs are queued per driven cycle
// and compared by an independent monitor on the falling edge.
module tb_incr_stream_monitor;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  incr_stream_monitor_if #(.WIDTH(8)) bus ();

  logic        a_locked, a_err, a_wrap;
  logic [15:0] a_ec, a_wc;
  logic [7:0]  a_last;
  logic        b_locked, b_err, b_wrap;
  logic [3:0]  b_ec, b_wc;
  logic [7:0]  b_last;

  incr_stream_monitor #(.WIDTH(8), .STEP(1), .LOCK_N(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_if(bus), .clear(clear),
    .locked(a_locked), .err_pulse(a_err), .wrap_pulse(a_wrap),
    .err_count(a_ec), .wrap_count(a_wc), .last_data(a_last)
  );

  incr_stream_monitor #(.WIDTH(8), .STEP(1), .LOCK_N(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_if(bus), .clear(clear),
    .locked(b_locked), .err_pulse(b_err), .wrap_pulse(b_wrap),
    .err_count(b_ec), .wrap_count(b_wc), .last_data(b_last)
  );

  typedef struct {
    int         cyc;
    logic       l;
    logic       e;
    logic       w;
    int         ec;
    int         wc;
    logic [7:0] last;
  } exp_t;

  exp_t sb[$];
  int   pcount = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) pcount <= pcount + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, pcount, act, req);
    end
  endtask

  // Monitor: compares every entry whose target edge has already happened.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() != 0 && sb[0].cyc <= pcount) begin
      e = sb.pop_front();
      chk("a_locked",     32'(a_locked), 32'(e.l));
      chk("a_err_pulse",  32'(a_err),    32'(e.e));
      chk("a_wrap_pulse", 32'(a_wrap),   32'(e.w));
      chk("a_err_count",  32'(a_ec),     32'(e.ec));
      chk("a_wrap_count", 32'(a_wc),     32'(e.wc));
      chk("a_last_data",  32'(a_last),   32'(e.last));
      chk("b_locked",     32'(b_locked), 32'(e.l));
      chk("b_err_pulse",  32'(b_err),    32'(e.e));
      chk("b_err_count",  32'(b_ec),     32'((e.ec > 15) ? 15 : e.ec));
      chk("b_wrap_count", 32'(b_wc),     32'((e.wc > 15) ? 15 : e.wc));
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic drv(input logic v, input logic [7:0] d, input logic c, input logic r,
                     input logic l, input logic e, input logic w,
                     input int ec, input int wc, input logic [7:0] last);
    exp_t x;
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_data  = d;
    clear        = c;
    rst          = r;
    x.cyc  = pcount + 1;
    x.l    = l;
    x.e    = e;
    x.w    = w;
    x.ec   = ec;
    x.wc   = wc;
    x.last = last;
    sb.push_back(x);
  endtask

  task automatic smp(input logic [7:0] d, input logic l, input logic e, input logic w,
                     input int ec, input int wc);
    drv(1'b1, d, 1'b0, 1'b0, l, e, w, ec, wc, d);
  endtask

  task automatic idle(input logic l, input int ec, input int wc, input logic [7:0] last);
    drv(1'b0, 8'h00, 1'b0, 1'b0, l, 1'b0, 1'b0, ec, wc, last);
  endtask

  task automatic clr();
    drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state
    drv(1'b0, 8'h00, 1'b0, 1'b1, 0, 0, 0, 0, 0, 8'h00);

    // 1: 00..05, lock one cycle after 04
    smp(8'h00, 0, 0, 0, 0, 0);
    smp(8'h01, 0, 0, 0, 0, 0);
    smp(8'h02, 0, 0, 0, 0, 0);
    smp(8'h03, 0, 0, 0, 0, 0);
    smp(8'h04, 1, 0, 0, 0, 0);
    smp(8'h05, 1, 0, 0, 0, 0);

    // 2: locked at FD, wrap through 00
    clr();
    smp(8'hF9, 0, 0, 0, 0, 0);
    smp(8'hFA, 0, 0, 0, 0, 0);
    smp(8'hFB, 0, 0, 0, 0, 0);
    smp(8'hFC, 0, 0, 0, 0, 0);
    smp(8'hFD, 1, 0, 0, 0, 0);
    smp(8'hFE, 1, 0, 0, 0, 0);
    smp(8'hFF, 1, 0, 0, 0, 0);
    smp(8'h00, 1, 0, 1, 0, 1);
    smp(8'h01, 1, 0, 0, 0, 1);
    idle(1, 0, 1, 8'h01);

    // 3: locked after 10, jump to 20, relock after 24
    clr();
    smp(8'h0C, 0, 0, 0, 0, 0);
    smp(8'h0D, 0, 0, 0, 0, 0);
    smp(8'h0E, 0, 0, 0, 0, 0);
    smp(8'h0F, 0, 0, 0, 0, 0);
    smp(8'h10, 1, 0, 0, 0, 0);
    smp(8'h20, 0, 1, 0, 1, 0);
    smp(8'h21, 0, 0, 0, 1, 0);
    smp(8'h22, 0, 0, 0, 1, 0);
    smp(8'h23, 0, 0, 0, 1, 0);
    smp(8'h24, 1, 0, 0, 1, 0);
    smp(8'h25, 1, 0, 0, 1, 0);
    idle(1, 1, 0, 8'h25);

    // 5: clear with a simultaneous valid drops the sample
    drv(1'b1, 8'h30, 1'b1, 1'b0, 0, 0, 0, 0, 0, 8'h00);
    smp(8'h31, 0, 0, 0, 0, 0);
    smp(8'h32, 0, 0, 0, 0, 0);
    smp(8'h33, 0, 0, 0, 0, 0);

    // 6: rst mid-acquire (streak=2), then gapped valids; acquire mismatch gives no err
    drv(1'b1, 8'h34, 1'b0, 1'b1, 0, 0, 0, 0, 0, 8'h00);
    smp(8'h50, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 8'h50);
    idle(0, 0, 0, 8'h50);
    smp(8'h51, 0, 0, 0, 0, 0);
    smp(8'h60, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 8'h60);
    smp(8'h61, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 8'h61);
    idle(0, 0, 0, 8'h61);
    idle(0, 0, 0, 8'h61);
    smp(8'h62, 0, 0, 0, 0, 0);
    smp(8'h63, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 8'h63);
    smp(8'h64, 1, 0, 0, 0, 0);
    idle(1, 0, 0, 8'h64);
    idle(1, 0, 0, 8'h64);
    smp(8'h65, 1, 0, 0, 0, 0);

    // Wrap while acquiring is counted
    clr();
    smp(8'hFE, 0, 0, 0, 0, 0);
    smp(8'hFF, 0, 0, 0, 0, 0);
    smp(8'h00, 0, 0, 1, 0, 1);
    smp(8'h01, 0, 0, 0, 0, 1);
    smp(8'h02, 1, 0, 0, 0, 1);

    // 4: 20 locked mismatches; 4-bit counter holds at 15
    clr();
    smp(8'h00, 0, 0, 0, 0, 0);
    for (int r = 0; r < 20; r++) begin
      smp(8'h01, 0, 0, 0, r, 0);
      smp(8'h02, 0, 0, 0, r, 0);
      smp(8'h03, 0, 0, 0, r, 0);
      smp(8'h04, 1, 0, 0, r, 0);
      smp(8'h00, 0, 1, 0, r + 1, 0);
    end
    idle(0, 20, 0, 8'h00);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
